// File: rtl/mem_access_unit.sv
// Memory-access stage: drives the data RAM over a req/ack handshake and feeds the Mem/WB register.
// Optional `MEM_TIMEOUT_EN` aborts an access after TIMEOUT WAIT cycles and pulses mem_err.
module mem_access_unit #(
  parameter int unsigned DATA_W  = 10,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              exe_valid,
  input  logic              exe_is_load,
  input  logic              exe_is_store,
  input  logic [ADDR_W-1:0] exe_addr,
  input  logic [DATA_W-1:0] exe_wdata,
  input  logic [DATA_W-1:0] exe_alu,
  input  logic              exe_gp_reg_wb,
  output logic              ram_req,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic              ram_ack,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              stall,
  output logic [DATA_W-1:0] wb_rdata,
  output logic              wb_gp_reg_wb,
  output logic              mem_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("mem_access_unit: TIMEOUT must be >= 1");
  end

  state_t              r_state;
  logic                r_req;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata_q;
  logic                r_wb_q;
  logic                w_mem_op;
  logic                w_store_only;

  assign w_mem_op     = exe_valid & (exe_is_load | exe_is_store);
  assign w_store_only = exe_is_store & ~exe_is_load;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] r_wait_cnt;
  logic             r_mem_err;
  logic             w_timeout;

  // Counter holds the number of completed WAIT cycles, so TIMEOUT-1 marks the last allowed one.
  assign w_timeout = (r_wait_cnt == CNT_W'(TIMEOUT - 1));
  assign mem_err   = r_mem_err;
`else
  assign mem_err   = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_req      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata_q  <= '0;
      r_wb_q     <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      r_wait_cnt <= '0;
      r_mem_err  <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_mem_op) begin
            r_addr  <= exe_addr;
            r_wdata <= exe_wdata;
            r_we    <= w_store_only;
            r_wb_q  <= exe_gp_reg_wb & exe_is_load;
            r_req   <= 1'b1;
            r_state <= S_WAIT;
`ifdef MEM_TIMEOUT_EN
            r_wait_cnt <= '0;
`endif
          end
        end
        S_WAIT: begin
`ifdef MEM_TIMEOUT_EN
          r_wait_cnt <= r_wait_cnt + 1'b1;
`endif
          if (ram_ack) begin
            r_req   <= 1'b0;
            r_state <= S_DONE;
            if (!r_we) begin
              r_rdata_q <= ram_rdata;
            end
          end
`ifdef MEM_TIMEOUT_EN
          else if (w_timeout) begin
            r_req     <= 1'b0;
            r_mem_err <= 1'b1;
            r_wb_q    <= 1'b0;
            r_state   <= S_DONE;
          end
`endif
        end
        S_DONE: begin
          r_state <= S_IDLE;
`ifdef MEM_TIMEOUT_EN
          r_wait_cnt <= '0;
          r_mem_err  <= 1'b0;
`endif
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ram_req   = r_req;
  assign ram_we    = r_we;
  assign ram_addr  = r_addr;
  assign ram_wdata = r_wdata;

  // IDLE passes the execute result straight through; DONE presents the captured access result.
  always_comb begin
    stall        = 1'b0;
    wb_rdata     = exe_alu;
    wb_gp_reg_wb = 1'b0;
    case (r_state)
      S_IDLE: begin
        stall        = w_mem_op;
        wb_rdata     = exe_alu;
        wb_gp_reg_wb = exe_valid & exe_gp_reg_wb & ~w_mem_op;
      end
      S_WAIT: begin
        stall        = 1'b1;
        wb_rdata     = r_rdata_q;
        wb_gp_reg_wb = 1'b0;
      end
      S_DONE: begin
        stall        = 1'b0;
        wb_rdata     = r_rdata_q;
        wb_gp_reg_wb = r_wb_q;
      end
      default: begin
        stall        = 1'b0;
        wb_rdata     = exe_alu;
        wb_gp_reg_wb = 1'b0;
      end
    endcase
  end

endmodule
